poly_key_board: RTL and testbench
=================================

# poly_key_board

Polyphonic keyboard voice engine: turns key presses into a mixed PCM sample stream with up to NUM_VOICES simultaneous notes, each sustained for a beat-counted hold after release. It is the parametrised successor to the single-voice key_board. It sits between the keypad decoder and the codec sample path, driven by the shared beat generator and the codec's generate_next_sample request.

## Interface
- NUM_VOICES, 2: number of voices; power of two, 1..8
- KEY_WIDTH, 4: key code width; code 0 = no key
- SAMPLE_WIDTH, 16: signed output sample width
- PHASE_WIDTH, 20: per-voice phase accumulator width; must be >= SAMPLE_WIDTH
- BASE_STEP, 64: phase increment per key code unit
- HOLD_BEATS, 4: beats a voice sustains after its key is released; 1..255
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  key input qualifier; key_val is ignored while low
- beat  in  1  one-cycle beat pulse
- generate_next_sample  in  1  sample request; each high cycle is one request
- mode  in  1  waveform select: 0 square, 1 sawtooth
- key_val  in  KEY_WIDTH  current key code
- key_note_sample  out  SAMPLE_WIDTH  signed mixed sample
- key_note_sample_ready  out  1  one-cycle strobe; key_note_sample is valid
- active_voices  out  NUM_VOICES  per-voice busy flags
- voice_steal  out  1  one-cycle pulse when an active voice is reallocated

## Operation
- Key event: a cycle with enable=1, key_val!=0, and either key_val differs from the registered previous qualified key or the previous cycle was unqualified. A qualified key is enable=1 and key_val!=0.
- Each voice holds: active flag, key code, phase (PHASE_WIDTH), hold counter (8 bit), held flag.
- Allocation on a key event, in priority order:
  - If an active voice already owns key_val, retrigger it: held=1, counter=HOLD_BEATS, phase kept.
  - Otherwise take the lowest-index inactive voice: phase=0, held=1, counter=HOLD_BEATS.
  - Otherwise steal the active voice with the smallest counter (ties go to the lowest index), reinitialise it as a fresh voice, and pulse voice_steal.
- Held voice: held stays 1 while the current qualified key equals its key code. Each beat reloads its counter to HOLD_BEATS.
- Released voice: held=0. Each beat decrements its counter. When the counter reaches 0, active clears.
- Step = (key code * BASE_STEP) mod 2^PHASE_WIDTH.
- Voice sample from the top SAMPLE_WIDTH phase bits p:
  - square: phase MSB 0 gives +(2^(SAMPLE_WIDTH-1)-1), MSB 1 gives -(2^(SAMPLE_WIDTH-1)-1)
  - sawtooth: p interpreted as signed
  - inactive voice: 0
- Mix: sum sign-extended by log2(NUM_VOICES) bits, arithmetic shift right by log2(NUM_VOICES), no saturation needed.
- On each request, every active voice adds its step to phase (wraps modulo 2^PHASE_WIDTH). The mix is taken from the pre-advance phases.

## Timing
- Reset: all voices inactive, phases 0, counters 0. key_note_sample=0, key_note_sample_ready=0, active_voices=0, voice_steal=0. Previous-key register cleared.
- Reset is asynchronous and may assert mid-note or mid-request. Everything clears immediately and no strobe follows.
- Allocation latency: key event in cycle N; active_voices and voice_steal visible at cycle N+1.
- Sample latency: request in cycle N; key_note_sample and ready=1 at N+1. ready is low on every cycle not preceded by a request.
- key_note_sample holds its value between strobes.
- Back-to-back requests give back-to-back strobes, one sample per request.
- Key event and request in the same cycle: the sample uses pre-allocation state, and a newly allocated voice first contributes on the next request.
- Key event and beat in the same cycle: the allocated voice gets counter=HOLD_BEATS, and all other voices apply the beat normally.
- Release detected in the same cycle as a beat: that beat decrements the counter.
- enable low counts as release for all voices. No key events occur while enable is low.

## Test plan
- Reset and idle: hold reset low 2 cycles, then 20 requests with no key -> key_note_sample=0 on every strobe, active_voices=0, ready exactly 1 cycle after each request.
- Single note, NUM_VOICES=2, square: key 1 held, 8 requests -> active_voices=01, step 64. Samples are ±16383 (half of ±32767 after the mix shift), sign set by phase MSB.
- Hold and decay, HOLD_BEATS=4: press key 3, release -> voice stays active through 3 beats and clears on the cycle after the 4th beat. A re-press of key 3 before then retriggers the same voice with its phase continuous.
- Two voices: key 1 then key 11 while key 1 decays -> active_voices=11. Sawtooth mix equals the average of both voice samples on every strobe.
- Voice steal: keys 1, 5, 9 in sequence within the hold window, NUM_VOICES=2 -> voice_steal pulses once. The voice with the smallest counter (lowest index on a tie) now carries key 9 with phase 0.
- Corner cases: key event, beat and request all in one cycle -> sample reflects the old voice set and the new voice counter=HOLD_BEATS. Reset asserted mid-decay -> all outputs 0 immediately.

Source files
------------

// File: rtl/poly_key_board.sv
// poly_key_board: polyphonic keyboard voice engine (alloc, hold/decay, mix).
// Ports: clk, reset (async, active low), enable, beat, generate_next_sample,
//   mode, key_val in; key_note_sample, key_note_sample_ready, active_voices,
//   voice_steal out.
module poly_key_board #(
   parameter int NUM_VOICES   = 2,
   parameter int KEY_WIDTH    = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int PHASE_WIDTH  = 20,
   parameter int BASE_STEP    = 64,
   parameter int HOLD_BEATS   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    beat,
   input  logic                    generate_next_sample,
   input  logic                    mode,
   input  logic [KEY_WIDTH-1:0]    key_val,
   output logic [SAMPLE_WIDTH-1:0] key_note_sample,
   output logic                    key_note_sample_ready,
   output logic [NUM_VOICES-1:0]   active_voices,
   output logic                    voice_steal
);

   localparam int LV = $clog2(NUM_VOICES);
   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int MW = SAMPLE_WIDTH + LV;
   localparam logic [7:0] LP_HOLD = 8'(HOLD_BEATS);
   localparam logic [PHASE_WIDTH-1:0] LP_BASE = PHASE_WIDTH'(BASE_STEP);
   localparam logic signed [SAMPLE_WIDTH-1:0] LP_MAX =
      SAMPLE_WIDTH'((64'd1 << (SAMPLE_WIDTH - 1)) - 64'd1);

   logic                   r_act   [NUM_VOICES];
   logic                   r_held  [NUM_VOICES];
   logic [KEY_WIDTH-1:0]   r_key   [NUM_VOICES];
   logic [PHASE_WIDTH-1:0] r_phase [NUM_VOICES];
   logic [7:0]             r_cnt   [NUM_VOICES];

   logic [KEY_WIDTH-1:0]    r_prev_key;
   logic                    r_prev_q;
   logic [SAMPLE_WIDTH-1:0] r_sample;
   logic                    r_ready;
   logic                    r_steal;

   logic                    w_q;
   logic                    w_event;
   logic                    w_hit;
   logic                    w_free;
   logic [IW-1:0]           w_hit_idx;
   logic [IW-1:0]           w_free_idx;
   logic [IW-1:0]           w_old_idx;
   logic [7:0]              w_old_cnt;
   logic [IW-1:0]           w_sel;
   logic                    w_steal;
   logic                    w_hold  [NUM_VOICES];
   logic [PHASE_WIDTH-1:0]  w_step  [NUM_VOICES];
   logic signed [SAMPLE_WIDTH-1:0] w_vs;
   logic signed [MW-1:0]    w_sum;
   logic [SAMPLE_WIDTH-1:0] w_mix;

   assign w_q     = enable && (key_val != '0);
   assign w_event = w_q && (!r_prev_q || (key_val != r_prev_key));

   // Candidate voices: owner of this key, lowest free, oldest (min counter).
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (r_act[i] && (r_key[i] == key_val)) begin
            w_hit     = 1'b1;
            w_hit_idx = IW'(i);
         end
         if (!r_act[i]) begin
            w_free     = 1'b1;
            w_free_idx = IW'(i);
         end
      end
      w_old_idx = '0;
      w_old_cnt = r_cnt[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (r_cnt[i] < w_old_cnt) begin
            w_old_cnt = r_cnt[i];
            w_old_idx = IW'(i);
         end
      end
      priority case (1'b1)
         w_hit:   w_sel = w_hit_idx;
         w_free:  w_sel = w_free_idx;
         default: w_sel = w_old_idx;
      endcase
      w_steal = w_event && !w_hit && !w_free;
   end

   // A released voice can only become held again through a key event.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_hold[i] = r_held[i] && w_q && (key_val == r_key[i]);
         w_step[i] = PHASE_WIDTH'(r_key[i]) * LP_BASE;
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_vs = '0;
         if (r_act[i]) begin
            if (mode)
               w_vs = $signed(r_phase[i][PHASE_WIDTH-1 -: SAMPLE_WIDTH]);
            else if (r_phase[i][PHASE_WIDTH-1])
               w_vs = -LP_MAX;
            else
               w_vs = LP_MAX;
         end
         w_sum = w_sum + MW'(w_vs);
      end
   end

   assign w_mix = SAMPLE_WIDTH'(w_sum >>> LV);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_act[i]   <= 1'b0;
            r_held[i]  <= 1'b0;
            r_key[i]   <= '0;
            r_phase[i] <= '0;
            r_cnt[i]   <= '0;
         end
         r_prev_key <= '0;
         r_prev_q   <= 1'b0;
         r_sample   <= '0;
         r_ready    <= 1'b0;
         r_steal    <= 1'b0;
      end else begin
         r_prev_key <= w_q ? key_val : '0;
         r_prev_q   <= w_q;
         r_ready    <= generate_next_sample;
         r_steal    <= w_steal;
         if (generate_next_sample)
            r_sample <= w_mix;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_event && (w_sel == IW'(i))) begin
               r_act[i]  <= 1'b1;
               r_held[i] <= 1'b1;
               r_key[i]  <= key_val;
               r_cnt[i]  <= LP_HOLD;
               // Retrigger keeps phase running; fresh or stolen restarts.
               if (!w_hit)
                  r_phase[i] <= '0;
               else if (generate_next_sample)
                  r_phase[i] <= r_phase[i] + w_step[i];
            end else if (r_act[i]) begin
               if (generate_next_sample)
                  r_phase[i] <= r_phase[i] + w_step[i];
               if (w_hold[i]) begin
                  r_held[i] <= 1'b1;
                  if (beat)
                     r_cnt[i] <= LP_HOLD;
               end else begin
                  r_held[i] <= 1'b0;
                  if (beat) begin
                     r_cnt[i] <= r_cnt[i] - 8'd1;
                     if (r_cnt[i] <= 8'd1)
                        r_act[i] <= 1'b0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++)
         active_voices[i] = r_act[i];
   end

   assign key_note_sample       = r_sample;
   assign key_note_sample_ready = r_ready;
   assign voice_steal           = r_steal;

endmodule

// File: tb/tb_poly_key_board.sv
// tb_poly_key_board: directed checks for poly_key_board.
// Drives on the falling edge, samples outputs on the next falling edge.
module tb_poly_key_board;

   localparam int NV = 2;
   localparam int KW = 4;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          beat = 1'b0;
   logic          gns = 1'b0;
   logic          mode = 1'b0;
   logic [KW-1:0] key_val = '0;
   logic [SW-1:0] sample;
   logic          ready;
   logic [NV-1:0] act;
   logic          steal;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   poly_key_board #(
      .NUM_VOICES(NV), .KEY_WIDTH(KW), .SAMPLE_WIDTH(SW),
      .PHASE_WIDTH(20), .BASE_STEP(64), .HOLD_BEATS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .beat(beat),
      .generate_next_sample(gns),
      .mode(mode),
      .key_val(key_val),
      .key_note_sample(sample),
      .key_note_sample_ready(ready),
      .active_voices(act),
      .voice_steal(steal)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      enable  = 1'b0;
      key_val = '0;
      beat    = 1'b0;
      gns     = 1'b0;
      reset   = 1'b0;
      tick();
      reset   = 1'b1;
   endtask

   task automatic req(input string tag, input int exp);
      gns = 1'b1;
      tick();
      gns = 1'b0;
      check(tag, int'($signed(sample)), exp);
      check({tag, "_rdy"}, int'(ready), 1);
   endtask

   task automatic beat_t();
      beat = 1'b1;
      tick();
      beat = 1'b0;
   endtask

   task automatic press(input int k);
      enable  = 1'b1;
      key_val = KW'(k);
      tick();
   endtask

   initial begin
      // reset and idle
      tick();
      tick();
      check("rst_smp", int'($signed(sample)), 0);
      check("rst_rdy", int'(ready), 0);
      check("rst_act", int'(act), 0);
      check("rst_steal", int'(steal), 0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         req("idle", 0);
         check("idle_act", int'(act), 0);
         tick();
         check("idle_gap", int'(ready), 0);
      end

      // single note, square then step check in sawtooth
      mode = 1'b0;
      press(1);
      check("one_act", int'(act), 1);
      check("one_steal", int'(steal), 0);
      for (int k = 0; k < 8; k++)
         req("sq", 16383);
      mode = 1'b1;
      req("saw_step", 16);

      // hold, retrigger with continuous phase, decay
      do_reset();
      mode = 1'b1;
      press(3);
      check("hd_act", int'(act), 1);
      req("hd0", 0);
      req("hd1", 6);
      repeat (5) beat_t();
      check("hd_held", int'(act), 1);
      press(0);
      beat_t();
      beat_t();
      check("hd_rel2", int'(act), 1);
      press(3);
      check("hd_retrig", int'(act), 1);
      req("hd_cont", 12);
      press(0);
      for (int b = 1; b <= 3; b++) begin
         beat_t();
         check("hd_decay", int'(act), 1);
      end
      beat_t();
      check("hd_clear", int'(act), 0);

      // two voices, sawtooth average
      do_reset();
      mode = 1'b1;
      press(1);
      press(0);
      press(11);
      check("two_act", int'(act), 3);
      for (int k = 0; k < 5; k++)
         req("two", 24 * k);
      check("two_act2", int'(act), 3);

      // voice steal: voice1 has the smaller counter
      do_reset();
      mode = 1'b1;
      press(1);
      check("st_a1", int'(act), 1);
      press(5);
      check("st_a2", int'(act), 3);
      check("st_no0", int'(steal), 0);
      req("st0", 0);
      req("st1", 12);
      press(1);
      check("st_retrig", int'(steal), 0);
      beat_t();
      press(9);
      check("st_pulse", int'(steal), 1);
      check("st_act", int'(act), 3);
      tick();
      check("st_once", int'(steal), 0);
      req("st_k0", 4);
      req("st_k1", 24);
      req("st_k2", 44);

      // key event, beat and request together
      do_reset();
      mode = 1'b1;
      press(1);
      req("c0", 0);
      req("c1", 2);
      key_val = 4'd5;
      beat    = 1'b1;
      gns     = 1'b1;
      tick();
      beat    = 1'b0;
      gns     = 1'b0;
      check("c_old", int'($signed(sample)), 4);
      check("c_rdy", int'(ready), 1);
      check("c_act", int'(act), 3);
      req("c_new", 6);
      press(0);
      repeat (3) beat_t();
      check("c_v0_gone", int'(act), 2);
      beat_t();
      check("c_v1_gone", int'(act), 0);

      // reset mid-decay with a request pending
      do_reset();
      mode = 1'b0;
      press(2);
      req("md_pre", 16383);
      press(0);
      beat_t();
      check("md_act", int'(act), 1);
      gns = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("md_smp", int'($signed(sample)), 0);
      check("md_rdy", int'(ready), 0);
      check("md_act0", int'(act), 0);
      check("md_steal", int'(steal), 0);
      tick();
      check("md_nostrobe", int'(ready), 0);
      gns = 1'b0;
      reset = 1'b1;
      tick();
      check("md_rdy2", int'(ready), 0);
      check("md_act2", int'(act), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
